// File: rtl/patch_window_seq.sv
// patch_window_seq
// ----------------
// Patch-window sequencer for the CoTM clause datapath. After an accepted start
// it walks every P x P patch position over a WIDTH x HEIGHT image in row-major
// order (x fastest), stepping by S in both axes. For each position it emits one
// beat on a valid/ready stream. A beat carries the window origin, the column
// and row masks covered by the window, and end-of-row / end-of-sweep flags.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             begin a sweep (sampled only while idle)
//   abort             terminate the current sweep without a done pulse
//   patch_size        P, captured when a start is accepted
//   stride            S, captured when a start is accepted
//   out_valid         a beat is presented
//   out_ready         consumer accepts the presented beat
//   xcor, ycor        window left column / top row
//   x_mask            bit i set when xcor <= i < xcor+P
//   y_mask            bit j set when ycor <= j < ycor+P
//   row_last          beat is the last x position of its row
//   last              beat is the final position of the sweep
//   busy              sequencer is not idle
//   done              one-cycle pulse after the final beat is accepted
//   cfg_err           one-cycle pulse when a start is rejected as illegal
module patch_window_seq #(
  parameter int WIDTH      = 32,
  parameter int HEIGHT     = 32,
  parameter int MAX_PATCH  = 7,
  parameter int MAX_STRIDE = 7,
  localparam int CW = $clog2(((WIDTH > HEIGHT) ? WIDTH : HEIGHT) + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        patch_size,
  input  logic [2:0]        stride,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW-1:0]     xcor,
  output logic [CW-1:0]     ycor,
  output logic [WIDTH-1:0]  x_mask,
  output logic [HEIGHT-1:0] y_mask,
  output logic              row_last,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Arithmetic runs one bit wider than the coordinates so x+S+P cannot wrap.
  localparam logic [CW:0] W_C    = (CW+1)'(WIDTH);
  localparam logic [CW:0] H_C    = (CW+1)'(HEIGHT);
  localparam logic [CW:0] MAXP_C = (CW+1)'(MAX_PATCH);
  localparam logic [CW:0] MAXS_C = (CW+1)'(MAX_STRIDE);

  // Run of P ones starting at column pos.
  function automatic logic [WIDTH-1:0] x_mask_f(input logic [CW:0] pos, input logic [2:0] p);
    logic [WIDTH-1:0] ones;
    ones = {WIDTH{1'b1}} >> (WIDTH - int'(p));
    return ones << pos;
  endfunction

  // Run of P ones starting at row pos.
  function automatic logic [HEIGHT-1:0] y_mask_f(input logic [CW:0] pos, input logic [2:0] p);
    logic [HEIGHT-1:0] ones;
    ones = {HEIGHT{1'b1}} >> (HEIGHT - int'(p));
    return ones << pos;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [2:0]        p_q, p_d;
  logic [2:0]        s_q, s_d;
  logic [CW:0]       x_q, x_d;
  logic [CW:0]       y_q, y_d;
  logic              out_valid_q, out_valid_d;
  logic [CW-1:0]     xcor_q, xcor_d;
  logic [CW-1:0]     ycor_q, ycor_d;
  logic [WIDTH-1:0]  x_mask_q, x_mask_d;
  logic [HEIGHT-1:0] y_mask_q, y_mask_d;
  logic              row_last_q, row_last_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;

  logic [CW:0] cfg_p_ext, cfg_s_ext, p_ext, s_ext;
  logic        cfg_legal;
  logic        row_end, col_end;

  assign cfg_p_ext = {{(CW-2){1'b0}}, patch_size};
  assign cfg_s_ext = {{(CW-2){1'b0}}, stride};
  assign p_ext     = {{(CW-2){1'b0}}, p_q};
  assign s_ext     = {{(CW-2){1'b0}}, s_q};

  assign cfg_legal = (cfg_p_ext != '0) && (cfg_p_ext <= MAXP_C) && (cfg_p_ext <= W_C) &&
                     (cfg_p_ext <= H_C) && (cfg_s_ext != '0) && (cfg_s_ext <= MAXS_C);

  // Current x/y is the last of its axis when one more step would leave the image.
  assign row_end = (x_q + s_ext + p_ext) > W_C;
  assign col_end = (y_q + s_ext + p_ext) > H_C;

  // Next-state, counter and output-register logic.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    s_d         = s_q;
    x_d         = x_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    xcor_d      = xcor_q;
    ycor_d      = ycor_q;
    x_mask_d    = x_mask_q;
    y_mask_d    = y_mask_q;
    row_last_d  = row_last_q;
    last_d      = last_q;
    cfg_err_d   = 1'b0;

    if (abort && (state_q != ST_IDLE)) begin
      // Abort beats any pending fire, so a final beat caught here gives no done.
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            if (cfg_legal) begin
              state_d = ST_RUN;
              p_d     = patch_size;
              s_d     = stride;
              x_d     = '0;
              y_d     = '0;
            end else begin
              cfg_err_d = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_RUN: begin
          // Load only into an empty or draining register so stalled data stays put.
          if (!out_valid_q || out_ready) begin
            out_valid_d = 1'b1;
            xcor_d      = x_q[CW-1:0];
            ycor_d      = y_q[CW-1:0];
            x_mask_d    = x_mask_f(x_q, p_q);
            y_mask_d    = y_mask_f(y_q, p_q);
            row_last_d  = row_end;
            last_d      = row_end && col_end;
            if (row_end) begin
              x_d = '0;
              y_d = y_q + s_ext;
            end else begin
              x_d = x_q + s_ext;
            end
            if (row_end && col_end) begin
              state_d = ST_DRAIN;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_DRAIN: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_DONE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      p_q         <= 3'd0;
      s_q         <= 3'd0;
      x_q         <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      xcor_q      <= '0;
      ycor_q      <= '0;
      x_mask_q    <= '0;
      y_mask_q    <= '0;
      row_last_q  <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      s_q         <= s_d;
      x_q         <= x_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      xcor_q      <= xcor_d;
      ycor_q      <= ycor_d;
      x_mask_q    <= x_mask_d;
      y_mask_q    <= y_mask_d;
      row_last_q  <= row_last_d;
      last_q      <= last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign xcor      = xcor_q;
  assign ycor      = ycor_q;
  assign x_mask    = x_mask_q;
  assign y_mask    = y_mask_q;
  assign row_last  = row_last_q;
  assign last      = last_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_patch_window_seq.sv
// Scoreboard bench for patch_window_seq (32x32 image). Stimulus tasks push the
// expected beat sequence into a queue when a sweep starts; an independent
// negedge monitor pops and compares on every accepted beat, and also checks
// stall stability and done timing.
module tb_patch_window_seq;
  localparam int W  = 32;
  localparam int H  = 32;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic [2:0]    patch_size = 3'd0;
  logic [2:0]    stride = 3'd0;
  logic          out_valid;
  logic [CW-1:0] xcor, ycor;
  logic [W-1:0]  x_mask;
  logic [H-1:0]  y_mask;
  logic          row_last, last, busy, done, cfg_err;

  always #5 clk = ~clk;

  patch_window_seq #(.WIDTH(W), .HEIGHT(H), .MAX_PATCH(7), .MAX_STRIDE(7)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .patch_size(patch_size), .stride(stride),
    .out_valid(out_valid), .out_ready(out_ready),
    .xcor(xcor), .ycor(ycor), .x_mask(x_mask), .y_mask(y_mask),
    .row_last(row_last), .last(last), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [W-1:0]  xm;
    logic [H-1:0]  ym;
    logic          rl;
    logic          ls;
  } beat_t;

  beat_t exp_q[$];
  beat_t cur;
  assign cur = {xcor, ycor, x_mask, y_mask, row_last, last};

  int n_cmp = 0;
  int n_err = 0;
  int beat_cnt = 0;

  logic          rdy_toggle = 1'b0;
  logic          stall_chk = 1'b0;
  logic [CW-1:0] lb_x, lb_y, first_rl_x;
  logic [W-1:0]  lb_xm;
  logic [H-1:0]  y3_mask;
  logic          first_rl_seen = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer: always ready, or alternating ready 1/0.
  always @(posedge clk) begin
    #1;
    if (rdy_toggle) out_ready = ~out_ready;
    else out_ready = 1'b1;
  end

  // Monitor: scoreboard pops, stall stability, done timing.
  beat_t held;
  logic  stall_prev = 1'b0;
  logic  last_fire_prev = 1'b0;
  always @(negedge clk) begin
    beat_t e;
    if (stall_prev && stall_chk) begin
      chk("stall_valid", 128'(out_valid), 128'(1));
      chk("stall_hold", 128'(cur), 128'(held));
    end
    if (last_fire_prev) chk("done_after_last", 128'(done), 128'(1));
    else if (done) chk("done_spurious", 128'(done), 128'(0));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got x=%0d y=%0d expected no beat", xcor, ycor);
      end else begin
        e = exp_q.pop_front();
        chk("beat", 128'(cur), 128'(e));
      end
      beat_cnt++;
      if (last) begin
        lb_x  = xcor;
        lb_y  = ycor;
        lb_xm = x_mask;
      end
      if (row_last && !first_rl_seen) begin
        first_rl_seen = 1'b1;
        first_rl_x    = xcor;
      end
      if (xcor == 6'd0 && ycor == 6'd3) y3_mask = y_mask;
    end
    stall_prev     = out_valid && !out_ready && rst_n;
    held           = cur;
    last_fire_prev = out_valid && out_ready && last && rst_n;
  end

  // Independent model: enumerate positions by index, masks bit by bit.
  task automatic push_sweep(input int p, input int s);
    int nx, ny;
    beat_t b;
    nx = (W - p) / s + 1;
    ny = (H - p) / s + 1;
    for (int yi = 0; yi < ny; yi++) begin
      for (int xi = 0; xi < nx; xi++) begin
        b.x = CW'(xi * s);
        b.y = CW'(yi * s);
        for (int i = 0; i < W; i++) b.xm[i] = (i >= xi * s) && (i < xi * s + p);
        for (int j = 0; j < H; j++) b.ym[j] = (j >= yi * s) && (j < yi * s + p);
        b.rl = (xi == nx - 1);
        b.ls = (xi == nx - 1) && (yi == ny - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic kick(input int p, input int s);
    beat_cnt = 0;
    first_rl_seen = 1'b0;
    push_sweep(p, s);
    @(posedge clk); #1;
    start = 1'b1; patch_size = 3'(p); stride = 3'(s);
    @(posedge clk); #1;
    start = 1'b0; patch_size = 3'd0; stride = 3'd0;
  endtask

  task automatic run_sweep(input int p, input int s, input logic toggle, input logic poke, input int n_exp);
    logic got;
    rdy_toggle = toggle;
    stall_chk  = toggle;
    kick(p, s);
    @(negedge clk);
    chk("latency_c1_valid", 128'(out_valid), 128'(0));
    chk("latency_c1_busy", 128'(busy), 128'(1));
    @(negedge clk);
    chk("latency_c2_valid", 128'(out_valid), 128'(1));
    got = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (poke && i == 5) begin
        start = 1'b1; patch_size = 3'd1; stride = 3'd1;
      end else if (poke && i == 6) begin
        start = 1'b0; patch_size = 3'd0; stride = 3'd0;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", 128'(got), 128'(1));
    chk("beat_count", 128'(beat_cnt), 128'(n_exp));
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    @(negedge clk);
    chk("done_one_cycle", 128'(done), 128'(0));
    chk("idle_after", 128'(busy), 128'(0));
    rdy_toggle = 1'b0;
    stall_chk  = 1'b0;
  endtask

  int bad_p[3] = '{0, 3, 0};
  int bad_s[3] = '{1, 0, 0};

  initial begin
    #3;
    chk("reset_outs", 128'({out_valid, xcor, ycor, x_mask, y_mask, row_last, last, busy, done, cfg_err}), 128'(0));
    #9 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // P=3,S=1: 30x30 positions back to back.
    run_sweep(3, 1, 1'b0, 1'b0, 900);
    chk("p3s1_last_x", 128'(lb_x), 128'(29));
    chk("p3s1_last_y", 128'(lb_y), 128'(29));
    chk("p3s1_last_xmask", 128'(lb_xm), 128'(32'hE000_0000));

    // P=7,S=3: 9x9 positions.
    run_sweep(7, 3, 1'b0, 1'b0, 81);
    chk("p7s3_rowlast_x", 128'(first_rl_x), 128'(24));
    chk("p7s3_ymask_y3", 128'(y3_mask), 128'(32'h0000_03F8));

    // P=5,S=5 under alternating backpressure: 6x6 positions.
    run_sweep(5, 5, 1'b1, 1'b0, 36);
    chk("p5s5_last_x", 128'(lb_x), 128'(25));
    chk("p5s5_last_y", 128'(lb_y), 128'(25));

    // Illegal configurations.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      start = 1'b1; patch_size = 3'(bad_p[k]); stride = 3'(bad_s[k]);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("cfg_err_pulse", 128'(cfg_err), 128'(1));
      chk("cfg_err_busy", 128'(busy), 128'(0));
      chk("cfg_err_valid", 128'(out_valid), 128'(0));
      @(negedge clk);
      chk("cfg_err_clear", 128'(cfg_err), 128'(0));
      chk("cfg_err_idle", 128'(busy), 128'(0));
    end

    // Abort around beat 10 of P=3,S=2, then a fresh sweep from (0,0).
    kick(3, 2);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (beat_cnt >= 10) break;
    end
    chk("abort_reached_beat10", 128'(beat_cnt >= 10), 128'(1));
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
    chk("abort_valid", 128'(out_valid), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    exp_q.delete();
    repeat (5) @(negedge clk);
    run_sweep(3, 2, 1'b0, 1'b0, 225);

    // Asynchronous reset mid-sweep, then a sweep with start poked while busy.
    kick(3, 1);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (beat_cnt >= 20) break;
    end
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    chk("midreset_outs", 128'({out_valid, xcor, ycor, x_mask, y_mask, row_last, last, busy, done, cfg_err}), 128'(0));
    @(posedge clk); #3 rst_n = 1'b1;
    exp_q.delete();
    run_sweep(7, 3, 1'b0, 1'b1, 81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
